// File: rtl/serial_frame_scheduler.sv
// Round-robin scheduler that shares one UART transmitter among three BCD reporters,
// sending each report as a 5-byte ASCII frame: ID, three digits, terminator.
module serial_frame_scheduler #(
  parameter logic [7:0] ID0  = 8'h44,
  parameter logic [7:0] ID1  = 8'h50,
  parameter logic [7:0] ID2  = 8'h53,
  parameter logic [7:0] TERM = 8'h23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  pedido,
  input  logic [11:0] dado0,
  input  logic [11:0] dado1,
  input  logic [11:0] dado2,
  input  logic        tx_pronto,
  output logic        tx_partida,
  output logic [7:0]  tx_dado,
  output logic [2:0]  pendente,
  output logic [1:0]  concedido,
  output logic        ocupado,
  output logic        fim_quadro,
  output logic [2:0]  descartado
);

  typedef enum logic [1:0] {OCIOSO, ENVIA, ESPERA, FIM} state_t;

  state_t      state, state_next;
  logic [11:0] holding [3];
  logic [11:0] dado_in [3];
  logic [11:0] frame;
  logic [2:0]  byte_idx;
  logic        grant;
  logic [1:0]  winner;
  logic [1:0]  cand1, cand2;

  assign dado_in[0] = dado0;
  assign dado_in[1] = dado1;
  assign dado_in[2] = dado2;

  function automatic logic [7:0] digit_ascii(input logic [3:0] n);
    return (n <= 4'd9) ? 8'h30 + {4'h0, n} : 8'h3F;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [1:0] id,
                                            input logic [11:0] f);
    logic [7:0] b;
    case (idx)
      3'd0: begin
        case (id)
          2'd0:    b = ID0;
          2'd1:    b = ID1;
          default: b = ID2;
        endcase
      end
      3'd1:    b = digit_ascii(f[11:8]);
      3'd2:    b = digit_ascii(f[7:4]);
      3'd3:    b = digit_ascii(f[3:0]);
      default: b = TERM;
    endcase
    return b;
  endfunction

  // Search starts just after the last served requester, so nobody starves.
  always_comb begin
    cand1  = (concedido == 2'd2) ? 2'd0 : concedido + 2'd1;
    cand2  = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
    grant  = 1'b0;
    winner = concedido;
    if (state == OCIOSO) begin
      if (pendente[cand1]) begin
        grant  = 1'b1;
        winner = cand1;
      end else if (pendente[cand2]) begin
        grant  = 1'b1;
        winner = cand2;
      end else if (pendente[concedido]) begin
        grant  = 1'b1;
        winner = concedido;
      end
    end
  end

  always_comb begin
    state_next = state;
    tx_partida = 1'b0;
    ocupado    = 1'b1;
    fim_quadro = 1'b0;
    case (state)
      OCIOSO: begin
        ocupado = 1'b0;
        if (grant) state_next = ENVIA;
      end
      ENVIA: begin
        tx_partida = 1'b1;
        state_next = ESPERA;
      end
      ESPERA: begin
        if (tx_pronto) state_next = (byte_idx == 3'd4) ? FIM : ENVIA;
      end
      FIM: begin
        fim_quadro = 1'b1;
        state_next = OCIOSO;
      end
      default: state_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= OCIOSO;
    else       state <= state_next;
  end

  // tx_dado is loaded one edge ahead so the byte is already valid in the ENVIA cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pendente   <= 3'b000;
      descartado <= 3'b000;
      frame      <= 12'h000;
      byte_idx   <= 3'd0;
      tx_dado    <= 8'h00;
      concedido  <= 2'd2;
      for (int i = 0; i < 3; i++) holding[i] <= 12'h000;
    end else begin
      if (grant) begin
        frame     <= holding[winner];
        concedido <= winner;
        byte_idx  <= 3'd0;
        tx_dado   <= frame_byte(3'd0, winner, holding[winner]);
      end else if (state == ESPERA && tx_pronto && byte_idx != 3'd4) begin
        byte_idx <= byte_idx + 3'd1;
        tx_dado  <= frame_byte(byte_idx + 3'd1, concedido, frame);
      end
      for (int i = 0; i < 3; i++) begin
        descartado[i] <= pedido[i] & pendente[i] & ~(grant && winner == 2'(i));
        if (pedido[i]) begin
          pendente[i] <= 1'b1;
          holding[i]  <= dado_in[i];
        end else if (grant && winner == 2'(i)) begin
          pendente[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_scheduler.sv
// Randomized and directed bench for serial_frame_scheduler; a transaction-level model
// predicts pending flags, drop pulses and the byte stream of each frame.
module tb_serial_frame_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  pedido = 3'b000;
  logic [11:0] dado0 = 12'h000, dado1 = 12'h000, dado2 = 12'h000;
  logic        tx_pronto = 1'b0;
  logic        tx_partida;
  logic [7:0]  tx_dado;
  logic [2:0]  pendente;
  logic [1:0]  concedido;
  logic        ocupado;
  logic        fim_quadro;
  logic [2:0]  descartado;

  serial_frame_scheduler dut (
    .clock(clock), .reset(reset), .pedido(pedido),
    .dado0(dado0), .dado1(dado1), .dado2(dado2),
    .tx_pronto(tx_pronto), .tx_partida(tx_partida), .tx_dado(tx_dado),
    .pendente(pendente), .concedido(concedido), .ocupado(ocupado),
    .fim_quadro(fim_quadro), .descartado(descartado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pending reports, the frame in flight and what each cycle should show.
  string       ids = "DPS";
  bit          m_pend [3];
  logic [11:0] m_hold [3];
  int          m_last, m_sent;
  bit          m_busy, m_started, m_awaiting, m_fim;
  logic [7:0]  m_frame [5];
  logic [7:0]  m_cur;
  bit          e_partida, e_fim;
  logic [2:0]  e_desc;

  function automatic logic [7:0] asciiOf(input logic [3:0] n);
    return (n > 4'd9) ? 8'd63 : 8'(48 + int'(n));
  endfunction

  function automatic bit anyPend();
    return m_pend[0] || m_pend[1] || m_pend[2];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 1'b0;
      m_hold[i] = 12'h000;
    end
    m_last = 2; m_sent = 0; m_busy = 0; m_started = 0; m_awaiting = 0; m_fim = 0;
    m_cur = 8'h00; e_partida = 0; e_fim = 0; e_desc = 3'b000;
  endtask

  task automatic modelStep(input logic [2:0] p, input logic [11:0] d0, input logic [11:0] d1,
                           input logic [11:0] d2, input logic pr);
    bit          granted;
    int          win;
    logic [11:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    granted = 0; win = 0;
    e_partida = 0; e_fim = 0; e_desc = 3'b000;
    if (!m_busy) begin
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_last + k) % 3;
        if (!granted && m_pend[c]) begin
          granted = 1;
          win = c;
        end
      end
      if (granted) begin
        m_frame[0] = ids[win];
        m_frame[1] = asciiOf(m_hold[win][11:8]);
        m_frame[2] = asciiOf(m_hold[win][7:4]);
        m_frame[3] = asciiOf(m_hold[win][3:0]);
        m_frame[4] = 8'h23;
        m_last = win; m_busy = 1; m_sent = 1; m_started = 1; m_awaiting = 0;
        m_cur = m_frame[0]; e_partida = 1; m_pend[win] = 0;
      end
    end else if (m_fim) begin
      m_fim = 0;
      m_busy = 0;
    end else if (m_started) begin
      m_started = 0;
      m_awaiting = 1;
    end else if (m_awaiting && pr) begin
      m_awaiting = 0;
      if (m_sent == 5) begin
        m_fim = 1;
        e_fim = 1;
      end else begin
        m_cur = m_frame[m_sent];
        m_sent++;
        m_started = 1;
        e_partida = 1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (p[i]) begin
        if (m_pend[i]) e_desc[i] = 1'b1;
        m_pend[i] = 1'b1;
        m_hold[i] = d[i];
      end
    end
  endtask

  // Stimulus knobs, UART emulation and observation logs.
  logic [2:0]  nxt_pedido = 3'b000;
  logic [11:0] nxt_d0 = 12'h000, nxt_d1 = 12'h000, nxt_d2 = 12'h000;
  int          dly_min = 1, dly_max = 4, resp_cnt = 0;
  bit          spur_en = 0;
  int          cyc = 0, first_part_cyc = -1, fim_cnt = 0, desc1_cnt = 0, desc_any = 0;
  logic [7:0]  log_q [$];

  task automatic applyStimulus();
    @(negedge clock);
    cyc++;
    checkOutput("pendente", pendente, {m_pend[2], m_pend[1], m_pend[0]});
    checkOutput("descartado", descartado, e_desc);
    checkOutput("fim_quadro", fim_quadro, e_fim);
    checkOutput("ocupado", ocupado, m_busy);
    checkOutput("tx_partida", tx_partida, e_partida);
    checkOutput("concedido", concedido, 32'(m_last));
    if (m_started || m_awaiting) checkOutput("tx_dado", tx_dado, m_cur);
    if (tx_partida === 1'b1) begin
      log_q.push_back(tx_dado);
      if (first_part_cyc < 0) first_part_cyc = cyc;
    end
    if (fim_quadro === 1'b1) fim_cnt++;
    if (descartado[1] === 1'b1) desc1_cnt++;
    if (descartado !== 3'b000) desc_any++;
    pedido = nxt_pedido;
    dado0 = nxt_d0; dado1 = nxt_d1; dado2 = nxt_d2;
    tx_pronto = 1'b0;
    if (m_started) begin
      resp_cnt = $urandom_range(dly_max, dly_min);
      if (spur_en && $urandom_range(3, 0) == 0) tx_pronto = 1'b1;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) tx_pronto = 1'b1;
    end
    nxt_pedido = 3'b000;
    @(posedge clock);
    modelStep(pedido, dado0, dado1, dado2, tx_pronto);
  endtask

  task automatic runCycles(input int n);
    repeat (n) applyStimulus();
  endtask

  task automatic runUntilIdle(input int budget);
    int c;
    c = 0;
    while ((m_busy || anyPend()) && c < budget) begin
      applyStimulus();
      c++;
    end
    if (c >= budget) checkOutput("idle_timeout", 32'(c), 32'(budget - 1));
    runCycles(2);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1; pedido = 3'b000; tx_pronto = 1'b0; resp_cnt = 0;
    modelReset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic checkFrame(input string tag, input int base, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] b4);
    logic [7:0] b [5];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4;
    if (log_q.size() < base + 5) checkOutput({tag, "_len"}, 32'(log_q.size()), 32'(base + 5));
    else for (int k = 0; k < 5; k++) checkOutput(tag, log_q[base + k], b[k]);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int req_cyc, guard;
    modelReset();
    repeat (2) @(negedge clock);
    checkOutput("rst_tx_dado", tx_dado, 8'h00);
    checkOutput("rst_tx_partida", tx_partida, 1'b0);
    checkOutput("rst_concedido", concedido, 2'd2);
    checkOutput("rst_pendente", pendente, 3'b000);
    checkOutput("rst_ocupado", ocupado, 1'b0);
    checkOutput("rst_fim", fim_quadro, 1'b0);
    checkOutput("rst_descartado", descartado, 3'b000);
    reset = 1'b0;

    $display("[TB] single frame");
    log_q.delete(); fim_cnt = 0; first_part_cyc = -1;
    dly_min = 10; dly_max = 10;
    nxt_d0 = 12'h123; nxt_pedido = 3'b001;
    applyStimulus();
    req_cyc = cyc;
    runUntilIdle(500);
    checkOutput("single_latency", 32'(first_part_cyc - req_cyc), 32'd2);
    checkFrame("single", 0, 8'h44, 8'h31, 8'h32, 8'h33, 8'h23);
    checkOutput("single_fim", 32'(fim_cnt), 32'd1);

    $display("[TB] round robin");
    doReset();
    log_q.delete(); fim_cnt = 0; dly_min = 1; dly_max = 3;
    nxt_d0 = 12'h001; nxt_d1 = 12'h002; nxt_d2 = 12'h003; nxt_pedido = 3'b111;
    applyStimulus();
    runUntilIdle(500);
    checkFrame("rr0", 0, 8'h44, 8'h30, 8'h30, 8'h31, 8'h23);
    checkFrame("rr1", 5, 8'h50, 8'h30, 8'h30, 8'h32, 8'h23);
    checkFrame("rr2", 10, 8'h53, 8'h30, 8'h30, 8'h33, 8'h23);
    checkOutput("rr_fim", 32'(fim_cnt), 32'd3);

    $display("[TB] fairness");
    log_q.delete(); fim_cnt = 0; desc_any = 0; guard = 0;
    nxt_d0 = 12'h111; nxt_d1 = 12'h222; nxt_pedido = 3'b011;
    while (fim_cnt < 4 && guard < 3000) begin
      applyStimulus();
      guard++;
      if (m_started && m_sent == 3 && fim_cnt < 2) nxt_pedido = 3'(1 << m_last);
    end
    if (guard >= 3000) checkOutput("fair_timeout", 32'(fim_cnt), 32'd4);
    runUntilIdle(500);
    if (log_q.size() < 20) checkOutput("fair_len", 32'(log_q.size()), 32'd20);
    else begin
      checkOutput("fair_id0", log_q[0], 8'h44);
      checkOutput("fair_id1", log_q[5], 8'h50);
      checkOutput("fair_id2", log_q[10], 8'h44);
      checkOutput("fair_id3", log_q[15], 8'h50);
    end
    checkOutput("fair_desc", 32'(desc_any), 32'd0);

    $display("[TB] overwrite");
    log_q.delete(); desc1_cnt = 0; guard = 0;
    nxt_d0 = 12'h999; nxt_pedido = 3'b001;
    applyStimulus();
    while (m_sent != 2 && guard < 100) begin
      applyStimulus();
      guard++;
    end
    nxt_d1 = 12'h045; nxt_pedido = 3'b010;
    applyStimulus();
    runCycles(3);
    nxt_d1 = 12'h067; nxt_pedido = 3'b010;
    applyStimulus();
    runUntilIdle(500);
    checkOutput("ow_desc1", 32'(desc1_cnt), 32'd1);
    checkOutput("ow_len", 32'(log_q.size()), 32'd10);
    checkFrame("ow_p", 5, 8'h50, 8'h30, 8'h36, 8'h37, 8'h23);

    $display("[TB] grant collision");
    log_q.delete(); desc_any = 0;
    nxt_d0 = 12'h111; nxt_pedido = 3'b001;
    applyStimulus();
    nxt_d0 = 12'h222; nxt_pedido = 3'b001;
    applyStimulus();
    runUntilIdle(500);
    checkOutput("col_desc", 32'(desc_any), 32'd0);
    checkFrame("col_a", 0, 8'h44, 8'h31, 8'h31, 8'h31, 8'h23);
    checkFrame("col_b", 5, 8'h44, 8'h32, 8'h32, 8'h32, 8'h23);

    $display("[TB] invalid digits");
    log_q.delete();
    nxt_d2 = 12'hA0F; nxt_pedido = 3'b100;
    applyStimulus();
    runUntilIdle(500);
    checkFrame("bad", 0, 8'h53, 8'h3F, 8'h30, 8'h3F, 8'h23);

    $display("[TB] reset mid-frame");
    guard = 0;
    nxt_d0 = 12'h456; nxt_pedido = 3'b001;
    applyStimulus();
    nxt_d1 = 12'h789; nxt_pedido = 3'b010;
    applyStimulus();
    while (!(m_started && m_sent == 3) && guard < 200) begin
      applyStimulus();
      guard++;
    end
    if (guard >= 200) checkOutput("mid_timeout", 32'(guard), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_tx_partida", tx_partida, 1'b0);
    checkOutput("mid_ocupado", ocupado, 1'b0);
    checkOutput("mid_pendente", pendente, 3'b000);
    checkOutput("mid_tx_dado", tx_dado, 8'h00);
    modelReset();
    pedido = 3'b000; tx_pronto = 1'b0; resp_cnt = 0;
    @(negedge clock);
    reset = 1'b0;
    log_q.delete();
    runCycles(40);
    checkOutput("mid_no_tx", 32'(log_q.size()), 32'd0);

    $display("[TB] random traffic");
    spur_en = 1; dly_min = 1; dly_max = 5;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++) nxt_pedido[i] = ($urandom_range(11, 0) == 0);
      nxt_d0 = 12'($urandom); nxt_d1 = 12'($urandom); nxt_d2 = 12'($urandom);
      applyStimulus();
    end
    runUntilIdle(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
